// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_pkg - shared encodings and sizes for the SD sector buffer          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sd_pkg;

    localparam int SECTOR_BYTES   = 512;
    localparam int ADDR_W         = 9;
    localparam int CNT_W          = 10;
    localparam int LBA_W          = 32;
    localparam int DEF_READ_SKIP  = 8;
    localparam int DEF_WRITE_SKIP = 7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_XFER     = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_sector_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_sector_ram - 512x8 sector RAM, one write port, two registered reads|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_sector_ram
    import sd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] haddr_i,
    output logic [7:0]        hrdata_o,
    input  logic [ADDR_W-1:0] saddr_i,
    output logic [7:0]        srdata_o
);

    logic [7:0] mem_q [SECTOR_BYTES];
    logic [7:0] hrdata_q;
    logic [7:0] srdata_q;

    // Storage is deliberately never reset so an aborted transfer keeps contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hrdata_q <= 8'h00;
            srdata_q <= 8'h00;
        end else begin
            hrdata_q <= mem_q[haddr_i];
            srdata_q <= mem_q[saddr_i];
        end
    end

    assign hrdata_o = hrdata_q;
    assign srdata_o = srdata_q;

endmodule
`default_nettype wire

// File: rtl/sd_block_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_block_buffer - sector buffer sequencing one SD block read/write    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_block_buffer
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int READ_SKIP      = DEF_READ_SKIP,
    parameter int WRITE_SKIP     = DEF_WRITE_SKIP
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [LBA_W-1:0]  cmd_lba_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic [7:0]        host_rdata_o,
    output logic              done_o,
    output logic              error_o,
    output logic              sd_op_code_o,
    output logic              sd_execute_o,
    output logic [LBA_W-1:0]  sd_block_address_o,
    output logic [7:0]        sd_outgoing_byte_o,
    input  logic [7:0]        sd_incoming_byte_i,
    input  logic              sd_finished_byte_i,
    input  logic              sd_finished_block_i,
    input  logic              sd_busy_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LO    = CNT_W'(READ_SKIP);
    localparam logic [CNT_W-1:0] RD_HI    = CNT_W'(READ_SKIP + SECTOR_BYTES);
    localparam logic [CNT_W-1:0] WR_LO    = CNT_W'(WRITE_SKIP);
    localparam logic [CNT_W-1:0] WR_HI    = CNT_W'(WRITE_SKIP + SECTOR_BYTES);

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               rdy_q, rdy_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               err_q, err_d;

    logic               w_in_rd;
    logic               w_in_wr;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [7:0]         w_ram_wdata;

    assign w_in_rd = (p_q >= RD_LO) && (p_q < RD_HI);
    assign w_in_wr = (p_q >= WR_LO) && (p_q < WR_HI);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        lba_d   = lba_q;
        p_d     = p_q;
        idx_d   = idx_q;
        rdy_d   = rdy_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    lba_d   = cmd_lba_i;
                    p_d     = '0;
                    idx_d   = '0;
                    rdy_d   = 1'b0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                // Two back-to-back idle cycles mean card init has really finished.
                if (sd_busy_i) begin
                    rdy_d = 1'b0;
                end else if (rdy_q) begin
                    state_d = S_ISSUE;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            S_ISSUE: begin
                tmo_d   = TW'(1);
                state_d = S_XFER;
            end
            S_XFER: begin
                tmo_d = tmo_q + TW'(1);
                if (sd_finished_byte_i) begin
                    if (p_q != '1) begin
                        p_d = p_q + CNT_W'(1);
                    end
                    if (write_q && w_in_wr && (idx_q != '1)) begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
                if (sd_finished_block_i) begin
                    state_d = S_FINISH;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            lba_q   <= '0;
            p_q     <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            lba_q   <= lba_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Host owns the write port only while idle; the card owns it during a read.
    assign w_ram_we    = ((state_q == S_IDLE) && host_we_i) ||
                         ((state_q == S_XFER) && !write_q && sd_finished_byte_i && w_in_rd);
    assign w_ram_addr  = (state_q == S_IDLE) ? host_addr_i : ADDR_W'(p_q - RD_LO);
    assign w_ram_wdata = (state_q == S_IDLE) ? host_wdata_i : sd_incoming_byte_i;

    sd_sector_ram u_ram (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .we_i     (w_ram_we),
        .waddr_i  (w_ram_addr),
        .wdata_i  (w_ram_wdata),
        .haddr_i  (host_addr_i),
        .hrdata_o (host_rdata_o),
        .saddr_i  (idx_q),
        .srdata_o (sd_outgoing_byte_o)
    );

    assign cmd_ready_o        = (state_q == S_IDLE);
    assign sd_execute_o       = (state_q == S_ISSUE);
    assign done_o             = (state_q == S_FINISH);
    assign error_o            = (state_q == S_FINISH) && err_q;
    assign sd_op_code_o       = write_q;
    assign sd_block_address_o = lba_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_block_buffer - vector table plus scoreboard bench               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sd_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, t_cmd_valid, cmd_write;
    logic [31:0] cmd_lba;
    logic        host_we;
    logic [8:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  sd_in;
    logic        fbyte, fblock, busy;

    logic        cmd_ready, done, error, op_code, execute;
    logic [7:0]  host_rdata, out_byte;
    logic [31:0] blk_addr;
    logic        t_cmd_ready, t_done, t_error, t_op_code, t_execute;
    logic [7:0]  t_host_rdata, t_out_byte;
    logic [31:0] t_blk_addr;

    always #5 clk = ~clk;

    sd_block_buffer #(.TIMEOUT_CYCLES(20000)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write), .cmd_lba_i(cmd_lba), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_rdata_o(host_rdata),
        .done_o(done), .error_o(error), .sd_op_code_o(op_code), .sd_execute_o(execute),
        .sd_block_address_o(blk_addr), .sd_outgoing_byte_o(out_byte),
        .sd_incoming_byte_i(sd_in), .sd_finished_byte_i(fbyte),
        .sd_finished_block_i(fblock), .sd_busy_i(busy)
    );

    sd_block_buffer #(.TIMEOUT_CYCLES(1000)) dut_tmo (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(t_cmd_valid), .cmd_ready_o(t_cmd_ready),
        .cmd_write_i(cmd_write), .cmd_lba_i(cmd_lba), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_rdata_o(t_host_rdata),
        .done_o(t_done), .error_o(t_error), .sd_op_code_o(t_op_code), .sd_execute_o(t_execute),
        .sd_block_address_o(t_blk_addr), .sd_outgoing_byte_o(t_out_byte),
        .sd_incoming_byte_i(sd_in), .sd_finished_byte_i(1'b0),
        .sd_finished_block_i(1'b0), .sd_busy_i(busy)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    task automatic sb_check(input logic [7:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            fail_now("scoreboard_underflow");
        end else begin
            e = sb.pop_front();
            check(e.name, {24'h0, act}, {24'h0, e.data});
        end
    endtask

    task automatic host_write(input logic [8:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [8:0] a, input logic [7:0] d, input string name);
        host_we = 1'b0; host_addr = a;
        sb.push_back('{name, d});
        tick();
        sb_check(host_rdata);
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] lba);
        cmd_write = wr; cmd_lba = lba; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_exec(input bit tmo_dut, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tmo_dut ? t_execute : execute) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(tmo_dut ? "tmo_exec_wait" : "exec_wait");
    endtask

    // Read op: skip bytes, n_data data bytes (i+offs), n_crc CRC bytes; block ends on last pulse.
    task automatic do_read(input logic [31:0] lba, input int n_data, input int n_crc,
                           input logic [7:0] offs);
        bit ok;
        int total;
        issue_cmd(1'b0, lba);
        wait_exec(1'b0, ok);
        check("rd_op_code", {31'h0, op_code}, 32'h0);
        check("rd_blk_addr", blk_addr, lba);
        tick();
        total = 8 + n_data + n_crc;
        for (int k = 0; k < total; k++) begin
            fbyte = 1'b1;
            if (k < 8) sd_in = (k == 7) ? 8'hFE : 8'hFF;
            else if (k < 8 + n_data) sd_in = 8'(k - 8) + offs;
            else sd_in = 8'hC0 + 8'(k);
            fblock = (k == total - 1);
            host_we = 1'b1; host_addr = 9'd0; host_wdata = 8'h77;
            tick();
        end
        fbyte = 1'b0; fblock = 1'b0; host_we = 1'b0;
        check("rd_done", {31'h0, done}, 32'h1);
        check("rd_error", {31'h0, error}, 32'h0);
        tick();
        check("rd_done_pulse", {31'h0, done}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n_exec, cyc;
        rst_n = 1'b0; cmd_valid = 1'b0; t_cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_lba = 32'h0; host_we = 1'b0; host_addr = 9'h0; host_wdata = 8'h0;
        sd_in = 8'h0; fbyte = 1'b0; fblock = 1'b0; busy = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_execute", {31'h0, execute}, 32'h0);
        check("rst_op_code", {31'h0, op_code}, 32'h0);
        check("rst_blk_addr", blk_addr, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_host_rdata", {24'h0, host_rdata}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Host port table: writes, then readbacks including write-then-read.
        tbl[0] = '{1'b1, 9'h000, 8'h11, 8'h00};
        tbl[1] = '{1'b1, 9'h1FF, 8'h22, 8'h00};
        tbl[2] = '{1'b1, 9'h100, 8'h33, 8'h00};
        tbl[3] = '{1'b0, 9'h000, 8'h00, 8'h11};
        tbl[4] = '{1'b0, 9'h1FF, 8'h00, 8'h22};
        tbl[5] = '{1'b0, 9'h100, 8'h00, 8'h33};
        tbl[6] = '{1'b1, 9'h000, 8'h44, 8'h00};
        tbl[7] = '{1'b0, 9'h000, 8'h00, 8'h44};
        tbl[8] = '{1'b1, 9'h001, 8'h55, 8'h00};
        tbl[9] = '{1'b0, 9'h001, 8'h00, 8'h55};
        for (int i = 0; i < 10; i++) begin
            host_we = tbl[i].we; host_addr = tbl[i].addr; host_wdata = tbl[i].wdata;
            if (!tbl[i].we) sb.push_back('{"tbl_host_rd", tbl[i].exp});
            tick();
            if (!tbl[i].we) sb_check(host_rdata);
        end
        host_we = 1'b0;

        // WRITE lba 0x10 presenting two copies of 0x00..0xFF.
        for (int i = 0; i < 512; i++) host_write(9'(i), 8'(i));
        issue_cmd(1'b1, 32'h10);
        check("wr_cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
        wait_exec(1'b0, ok);
        check("wr_op_code", {31'h0, op_code}, 32'h1);
        check("wr_blk_addr", blk_addr, 32'h10);
        tick();
        check("wr_exec_one_cycle", {31'h0, execute}, 32'h0);
        for (int i = 0; i < 512; i++) sb.push_back('{"wr_byte", 8'(i)});
        for (int p = 0; p < 521; p++) begin
            fbyte = 1'b1;
            if (p >= 7 && p < 519) sb_check(out_byte);
            else if (p >= 519) check("wr_idx_saturate", {24'h0, out_byte}, 32'hFF);
            tick();
            fbyte = 1'b0;
            tick();
            tick();
        end
        check("wr_sb_drained", sb.size(), 0);
        fblock = 1'b1;
        tick();
        fblock = 1'b0;
        check("wr_done", {31'h0, done}, 32'h1);
        check("wr_error", {31'h0, error}, 32'h0);
        tick();
        check("wr_done_pulse", {31'h0, done}, 32'h0);
        check("wr_back_idle", {31'h0, cmd_ready}, 32'h1);

        // Busy hold-off, including a single idle glitch and an ignored second command.
        busy = 1'b1;
        issue_cmd(1'b0, 32'h77);
        cmd_lba = 32'h99; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_exec = 0;
        for (int k = 0; k < 50; k++) begin
            busy = (k != 25);
            tick();
            if (execute) n_exec++;
        end
        check("busy_no_exec", n_exec, 0);
        check("busy_lba_not_requeued", blk_addr, 32'h77);
        busy = 1'b0;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            cyc++;
            if (execute) break;
        end
        check("busy_exec_latency", cyc, 2);
        n_exec = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) fblock = 1'b1;
            tick();
            if (execute) n_exec++;
            if (done) break;
            fblock = 1'b0;
        end
        fblock = 1'b0;
        check("busy_single_exec", n_exec, 1);
        check("busy_done", {31'h0, done}, 32'h1);
        tick();

        // Reset in the middle of a read data phase.
        issue_cmd(1'b0, 32'h20);
        wait_exec(1'b0, ok);
        tick();
        for (int k = 0; k < 108; k++) begin
            fbyte = 1'b1; sd_in = 8'(k);
            tick();
        end
        fbyte = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_blk_addr", blk_addr, 32'h0);
        fblock = 1'b1;
        n_exec = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) n_exec++;
            fblock = 1'b0;
        end
        check("mid_rst_no_done", n_exec, 0);

        // Full READ lba 5 over a buffer pre-filled with the complement pattern.
        for (int i = 0; i < 512; i++) host_write(9'(i), ~8'(i));
        do_read(32'h5, 512, 2, 8'h00);
        for (int i = 0; i < 512; i++) host_read(9'(i), 8'(i), "rd_buffer");

        // Short READ: block ends on the 10th data byte, rest of buffer kept.
        do_read(32'h6, 10, 0, 8'hA0);
        for (int i = 0; i < 10; i++) host_read(9'(i), 8'hA0 + 8'(i), "short_rd_new");
        host_read(9'd10, 8'd10, "short_rd_kept");
        host_read(9'h1FF, 8'hFF, "short_rd_kept_last");

        // Timeout on the second instance (TIMEOUT_CYCLES=1000).
        cmd_write = 1'b0; cmd_lba = 32'h3; t_cmd_valid = 1'b1;
        tick();
        t_cmd_valid = 1'b0;
        wait_exec(1'b1, ok);
        cyc = 0;
        while (!t_done && cyc < 1100) begin
            tick();
            cyc++;
        end
        check("tmo_cycles", cyc, 1000);
        check("tmo_error", {31'h0, t_error}, 32'h1);
        tick();
        check("tmo_done_pulse", {31'h0, t_done}, 32'h0);
        check("tmo_back_idle", {31'h0, t_cmd_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
